multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM controller that sequences a shared-resource multicycle RV32I datapath.
//  The datapath has one ALU, one unified memory port, and IR/OldPC/ALUOut/Data registers.
//  The FSM issues per-state mux selects, write enables and ALUControl.
//  It supports the same instruction subset as the single-cycle core:
//  lw, sw, R/I ALU ops (incl. xor/sll/srl/sra), beq/bne/blt/bge, jal.
// PARAMETERS
//  CNT_W         32  width of the performance counters (MCYC_PERF_EN only)
//  ILLEGAL_HALT  1   1: an unknown opcode parks the FSM in HALT; 0: treat it as NOP and return to FETCH
// PORTS
//  clk          in   1   clock, rising edge
//  reset_n      in   1   asynchronous reset, active-low
//  op           in   7   IR[6:0]
//  funct3       in   3   IR[14:12]
//  funct7b5     in   1   IR[30]
//  zero         in   1   ALU result == 0
//  pc_write     out  1   PC register load
//  adr_src      out  1   memory address: 0 = PC, 1 = ALUOut
//  mem_write    out  1   memory write strobe
//  ir_write     out  1   load IR and OldPC
//  result_src   out  2   00 = ALUOut, 01 = Data, 10 = ALUResult
//  alu_src_a    out  2   00 = PC, 01 = OldPC, 10 = rs1
//  alu_src_b    out  2   00 = rs2, 01 = ImmExt, 10 = 4
//  reg_write    out  1   register file write
//  imm_src      out  2   00 = I, 01 = S, 10 = B, 11 = J; decoded from op in every state
//  alu_control  out  4   0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt,
//                        0110 sll, 0111 srl, 1000 sra
//  state        out  4   current state encoding, for debug
//  illegal      out  1   high while in HALT
// BEHAVIOUR
//  - State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXR=6, ALUWB=7,
//    EXI=8, JAL=9, BRANCH=10, HALT=15.
//  - Reset: while reset_n=0, state=FETCH and every output is forced to 0.
//    The first FETCH executes on the first rising edge after release.
//  - Outputs are pure functions of state (plus op/funct fields where noted). No output depends on zero
//    except pc_write in BRANCH. Write enables not listed for a state are 0.
//  - FETCH: adr_src=0, ir_write=1, src_a=00, src_b=10, add, result_src=10, pc_write=1. Next: DECODE.
//  - DECODE: src_a=01, src_b=01, add (branch/jal target into ALUOut). Next state by op:
//    0000011/0100011 -> MEMADR; 0110011 -> EXR; 0010011 -> EXI; 1100011 -> BRANCH;
//    1101111 -> JAL; else HALT (ILLEGAL_HALT=1) or FETCH (ILLEGAL_HALT=0).
//  - MEMADR: src_a=10, src_b=01, add. Next: MEMRD if op[5]=0, else MEMWR.
//  - MEMRD: adr_src=1. Next: MEMWB.
//  - MEMWB: result_src=01, reg_write=1. Next: FETCH.
//  - MEMWR: adr_src=1, mem_write=1. Next: FETCH.
//  - EXR: src_a=10, src_b=00, ALU decode. Next: ALUWB.
//  - EXI: src_a=10, src_b=01, ALU decode. Next: ALUWB.
//  - ALUWB: result_src=00, reg_write=1. Next: FETCH.
//  - JAL: src_a=01, src_b=10, add, result_src=00, pc_write=1. Next: ALUWB (rd = OldPC+4).
//  - BRANCH: src_a=10, src_b=00, result_src=00.
//    ALU op: funct3 000/001 -> sub; 100/101 -> slt; other funct3 -> sub, never taken.
//    pc_write = (f3==000 & zero) | (f3==001 & ~zero) | (f3==100 & ~zero) | (f3==101 & zero).
//    Next: FETCH.
//  - HALT: all enables 0, illegal=1. Stays in HALT until reset_n falls.
//  - ALU decode (EXR/EXI):
//    f3 000: sub if op[5] & funct7b5, else add
//    f3 001: sll
//    f3 010: slt
//    f3 100: xor
//    f3 101: sra if funct7b5, else srl
//    f3 110: or
//    f3 111: and
//    f3 011: add (unsupported; never X)
//  - Cycles per instruction: lw 5, sw 4, R 4, I 4, jal 4, branch 3 (taken or not).
//  - reset_n asserted mid-instruction: the instruction is abandoned immediately and no further
//    write enable pulses. Any partial register or memory update already clocked is not undone.
//  - No output is ever X in any reachable state. Unreachable state encodings go to FETCH.
// CONFIGURATION
//  MCYC_PERF_EN defined: adds outputs cycle_cnt[CNT_W] and instret_cnt[CNT_W], both reset to 0.
//    cycle_cnt increments every clock outside HALT.
//    instret_cnt increments on each transition into FETCH from a non-FETCH state.
//    Both wrap modulo 2^CNT_W.
//  MCYC_PERF_EN undefined: neither port nor the counter logic exists.
// TESTING
//  - Reset hold, then release: all outputs 0 during reset; cycle 1 after release is FETCH with
//    pc_write=1, ir_write=1.
//  - op=0000011 (lw): states 0,1,2,3,4 in order; reg_write=1 only in state 4; result_src=01 there.
//  - op=0100011 (sw): states 0,1,2,5; mem_write=1 exactly one cycle, with adr_src=1.
//  - op=0110011, f3=101, f7b5=1: EXR alu_control=1000; with f7b5=0: 0111.
//    Then ALUWB with reg_write=1.
//  - op=1100011: f3=001, zero=0 -> pc_write=1; f3=000, zero=0 -> 0; f3=100 -> alu_control=0101.
//  - op=1111111 with ILLEGAL_HALT=1: HALT, illegal=1 held 10 cycles.
//    reset_n pulse returns to FETCH.
//    With MCYC_PERF_EN, instret_cnt=3 after lw, sw, add.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Moore FSM controller for a shared-resource multicycle RV32I datapath (one ALU,
// one unified memory port, IR/OldPC/ALUOut/Data registers). Each state drives
// the datapath mux selects, write enables and ALU operation.
//
// Parameters:
//   CNT_W         width of the performance counters (MCYC_PERF_EN builds only)
//   ILLEGAL_HALT  1: unknown opcode parks the FSM in HALT; 0: treated as NOP
//
// Ports:
//   clk, reset_n              clock (rising edge), async active-low reset
//   op, funct3, funct7b5      instruction fields from IR
//   zero                      ALU result == 0 (branch resolution)
//   pc_write, adr_src, mem_write, ir_write, reg_write    datapath enables/selects
//   result_src, alu_src_a, alu_src_b, imm_src, alu_control
//   state                     current state encoding (debug)
//   illegal                   high while in HALT
//   cycle_cnt, instret_cnt    performance counters (MCYC_PERF_EN only)
//
// Configuration macro: MCYC_PERF_EN adds the cycle / retired-instruction counters.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int CNT_W        = 32,
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic [1:0] imm_src,
    output logic [3:0] alu_control,
    output logic [3:0] state,
    output logic       illegal
`ifdef MCYC_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXR    = 4'd6,
        S_ALUWB  = 4'd7,
        S_EXI    = 4'd8,
        S_JAL    = 4'd9,
        S_BRANCH = 4'd10,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    state_t state_q, state_d;

    // ALU operation for register/immediate arithmetic. sub only exists for the
    // R-type form (op[5]=1); addi with IR[30] set is still an add. f3=011 is
    // unsupported and falls back to add so the output is never unknown.
    function automatic logic [3:0] alu_decode(input logic op5, input logic [2:0] f3,
                                              input logic f7b5);
        logic [3:0] res;
        case (f3)
            3'b000:  res = (op5 && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  res = ALU_SLL;
            3'b010:  res = ALU_SLT;
            3'b100:  res = ALU_XOR;
            3'b101:  res = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  res = ALU_OR;
            3'b111:  res = ALU_AND;
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXR;
                    7'b0010011:             state_d = S_EXI;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b1101111:             state_d = S_JAL;
                    default:                state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR: state_d = op[5] ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = S_FETCH;
            S_EXR:    state_d = S_ALUWB;
            S_EXI:    state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_JAL:    state_d = S_ALUWB;
            S_BRANCH: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output logic. Everything is computed as if running, then forced to zero
    // while reset_n is low so nothing pulses during reset even though the
    // state register already holds FETCH.
    always_comb begin
        logic       pcw, adr, memw, irw, rw, ill;
        logic [1:0] rs, sa, sb, imm;
        logic [3:0] alu;

        pcw  = 1'b0;
        adr  = 1'b0;
        memw = 1'b0;
        irw  = 1'b0;
        rw   = 1'b0;
        ill  = 1'b0;
        rs   = 2'b00;
        sa   = 2'b00;
        sb   = 2'b00;
        alu  = ALU_ADD;

        // Immediate format is a function of the opcode alone.
        case (op)
            7'b0100011: imm = 2'b01;
            7'b1100011: imm = 2'b10;
            7'b1101111: imm = 2'b11;
            default:    imm = 2'b00;
        endcase

        case (state_q)
            S_FETCH: begin
                irw = 1'b1;
                sb  = 2'b10;
                rs  = 2'b10;
                pcw = 1'b1;
            end
            S_DECODE: begin
                sa = 2'b01;
                sb = 2'b01;
            end
            S_MEMADR: begin
                sa = 2'b10;
                sb = 2'b01;
            end
            S_MEMRD:  adr = 1'b1;
            S_MEMWB: begin
                rs = 2'b01;
                rw = 1'b1;
            end
            S_MEMWR: begin
                adr  = 1'b1;
                memw = 1'b1;
            end
            S_EXR: begin
                sa  = 2'b10;
                alu = alu_decode(op[5], funct3, funct7b5);
            end
            S_EXI: begin
                sa  = 2'b10;
                sb  = 2'b01;
                alu = alu_decode(op[5], funct3, funct7b5);
            end
            S_ALUWB:  rw = 1'b1;
            S_JAL: begin
                sa  = 2'b01;
                sb  = 2'b10;
                pcw = 1'b1;
            end
            S_BRANCH: begin
                sa  = 2'b10;
                // beq/bne compare via sub, blt/bge via slt; unsupported
                // funct3 values use sub and never take the branch.
                alu = (funct3 == 3'b100 || funct3 == 3'b101) ? ALU_SLT : ALU_SUB;
                pcw = ((funct3 == 3'b000) &&  zero) ||
                      ((funct3 == 3'b001) && !zero) ||
                      ((funct3 == 3'b100) && !zero) ||
                      ((funct3 == 3'b101) &&  zero);
            end
            S_HALT:   ill = 1'b1;
            default: ;
        endcase

        pc_write    = reset_n & pcw;
        adr_src     = reset_n & adr;
        mem_write   = reset_n & memw;
        ir_write    = reset_n & irw;
        reg_write   = reset_n & rw;
        illegal     = reset_n & ill;
        result_src  = reset_n ? rs  : 2'b00;
        alu_src_a   = reset_n ? sa  : 2'b00;
        alu_src_b   = reset_n ? sb  : 2'b00;
        imm_src     = reset_n ? imm : 2'b00;
        alu_control = reset_n ? alu : 4'b0000;
        state       = reset_n ? state_q : 4'b0000;
    end

`ifdef MCYC_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

    // An instruction retires whenever the FSM re-enters FETCH from elsewhere.
    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != S_HALT) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
        if (state_d == S_FETCH && state_q != S_FETCH) begin
            instret_cnt_d = instret_cnt_q + 1'b1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed testbench for multicycle_ctrl. Each scenario task drives an opcode
// and compares the full output bundle cycle by cycle against hand-written
// expected vectors. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [3:0] alu_control, state;
`ifdef MCYC_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl #(.CNT_W(32), .ILLEGAL_HALT(1'b1)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .reg_write   (reg_write),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .state       (state),
        .illegal     (illegal)
`ifdef MCYC_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds an expected output vector, fields in port order:
    // pc_write adr_src mem_write ir_write result_src alu_src_a alu_src_b
    // reg_write imm_src alu_control state illegal
    function automatic logic [21:0] pack(input logic pcw, input logic adr, input logic memw,
                                         input logic irw, input logic [1:0] rs,
                                         input logic [1:0] sa, input logic [1:0] sb,
                                         input logic rw, input logic [1:0] imm,
                                         input logic [3:0] alu, input logic [3:0] st,
                                         input logic ill);
        return {pcw, adr, memw, irw, rs, sa, sb, rw, imm, alu, st, ill};
    endfunction

    function automatic logic [21:0] observed();
        return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                reg_write, imm_src, alu_control, state, illegal};
    endfunction

    // Reset hold with all outputs zero, then release into FETCH.
    task automatic test_reset();
        logic [21:0] got;
        reset_n = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
        @(negedge clk);
        got = observed();
        checks++;
        if (got !== 22'h0) begin
            failures++;
            $display("[TB] FAIL reset_hold got=%h expected=%h", got, 22'h0);
        end
        op = 7'b0100011;
        #1;
        got = observed();
        checks++;
        if (got !== 22'h0) begin
            failures++;
            $display("[TB] FAIL reset_hold_op got=%h expected=%h", got, 22'h0);
        end
        @(negedge clk);
        op = 7'b0;
        reset_n = 1'b1;
        #1;
        got = observed();
        checks++;
        if (got !== pack(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,4'h0,4'd0,0)) begin
            failures++;
            $display("[TB] FAIL reset_release got=%h expected=%h", got,
                     pack(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,4'h0,4'd0,0));
        end
    endtask

    task automatic test_lw();
        logic [21:0] exp_v [5];
        logic [21:0] got;
        exp_v[0] = pack(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,4'h0,4'd0,0);
        exp_v[1] = pack(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,4'h0,4'd1,0);
        exp_v[2] = pack(0,0,0,0,2'b00,2'b10,2'b01,0,2'b00,4'h0,4'd2,0);
        exp_v[3] = pack(0,1,0,0,2'b00,2'b00,2'b00,0,2'b00,4'h0,4'd3,0);
        exp_v[4] = pack(0,0,0,0,2'b01,2'b00,2'b00,1,2'b00,4'h0,4'd4,0);
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            got = observed();
            checks++;
            if (got !== exp_v[i]) begin
                failures++;
                $display("[TB] FAIL lw cycle=%0d got=%h expected=%h", i, got, exp_v[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_sw();
        logic [21:0] exp_v [4];
        logic [21:0] got;
        exp_v[0] = pack(1,0,0,1,2'b10,2'b00,2'b10,0,2'b01,4'h0,4'd0,0);
        exp_v[1] = pack(0,0,0,0,2'b00,2'b01,2'b01,0,2'b01,4'h0,4'd1,0);
        exp_v[2] = pack(0,0,0,0,2'b00,2'b10,2'b01,0,2'b01,4'h0,4'd2,0);
        exp_v[3] = pack(0,1,1,0,2'b00,2'b00,2'b00,0,2'b01,4'h0,4'd5,0);
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            got = observed();
            checks++;
            if (got !== exp_v[i]) begin
                failures++;
                $display("[TB] FAIL sw cycle=%0d got=%h expected=%h", i, got, exp_v[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_r_type(input string nm, input logic [2:0] f3, input logic f7,
                               input logic [3:0] exp_alu);
        logic [21:0] exp_v [4];
        logic [21:0] got;
        exp_v[0] = pack(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,4'h0,4'd0,0);
        exp_v[1] = pack(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,4'h0,4'd1,0);
        exp_v[2] = pack(0,0,0,0,2'b00,2'b10,2'b00,0,2'b00,exp_alu,4'd6,0);
        exp_v[3] = pack(0,0,0,0,2'b00,2'b00,2'b00,1,2'b00,4'h0,4'd7,0);
        op = 7'b0110011; funct3 = f3; funct7b5 = f7; zero = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            got = observed();
            checks++;
            if (got !== exp_v[i]) begin
                failures++;
                $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", nm, i, got, exp_v[i]);
            end
        end
        @(negedge clk);
    endtask

    // addi with IR[30] set must still add (sub exists only for R-type).
    task automatic test_addi();
        logic [21:0] exp_v [4];
        logic [21:0] got;
        exp_v[0] = pack(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,4'h0,4'd0,0);
        exp_v[1] = pack(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,4'h0,4'd1,0);
        exp_v[2] = pack(0,0,0,0,2'b00,2'b10,2'b01,0,2'b00,4'h0,4'd8,0);
        exp_v[3] = pack(0,0,0,0,2'b00,2'b00,2'b00,1,2'b00,4'h0,4'd7,0);
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1; zero = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            got = observed();
            checks++;
            if (got !== exp_v[i]) begin
                failures++;
                $display("[TB] FAIL addi cycle=%0d got=%h expected=%h", i, got, exp_v[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_branch();
        logic [2:0]  f3_t   [6] = '{3'b001, 3'b000, 3'b000, 3'b100, 3'b101, 3'b010};
        logic        zero_t [6] = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1};
        logic        pcw_t  [6] = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0};
        logic [3:0]  alu_t  [6] = '{4'h1,   4'h1,   4'h1,   4'h5,   4'h5,   4'h1};
        logic [21:0] exp_v  [3];
        logic [21:0] got;
        for (int c = 0; c < 6; c++) begin
            exp_v[0] = pack(1,0,0,1,2'b10,2'b00,2'b10,0,2'b10,4'h0,4'd0,0);
            exp_v[1] = pack(0,0,0,0,2'b00,2'b01,2'b01,0,2'b10,4'h0,4'd1,0);
            exp_v[2] = pack(pcw_t[c],0,0,0,2'b00,2'b10,2'b00,0,2'b10,alu_t[c],4'd10,0);
            op = 7'b1100011; funct3 = f3_t[c]; funct7b5 = 1'b0; zero = zero_t[c];
            #1;
            for (int i = 0; i < 3; i++) begin
                if (i > 0) @(negedge clk);
                got = observed();
                checks++;
                if (got !== exp_v[i]) begin
                    failures++;
                    $display("[TB] FAIL branch case=%0d cycle=%0d got=%h expected=%h",
                             c, i, got, exp_v[i]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jal();
        logic [21:0] exp_v [4];
        logic [21:0] got;
        exp_v[0] = pack(1,0,0,1,2'b10,2'b00,2'b10,0,2'b11,4'h0,4'd0,0);
        exp_v[1] = pack(0,0,0,0,2'b00,2'b01,2'b01,0,2'b11,4'h0,4'd1,0);
        exp_v[2] = pack(1,0,0,0,2'b00,2'b01,2'b10,0,2'b11,4'h0,4'd9,0);
        exp_v[3] = pack(0,0,0,0,2'b00,2'b00,2'b00,1,2'b11,4'h0,4'd7,0);
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            got = observed();
            checks++;
            if (got !== exp_v[i]) begin
                failures++;
                $display("[TB] FAIL jal cycle=%0d got=%h expected=%h", i, got, exp_v[i]);
            end
        end
        @(negedge clk);
    endtask

    // Reset asserted in the middle of a lw: outputs drop to zero at once.
    task automatic test_mid_reset();
        logic [21:0] got;
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        got = observed();
        checks++;
        if (got !== 22'h0) begin
            failures++;
            $display("[TB] FAIL mid_reset got=%h expected=%h", got, 22'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        got = observed();
        checks++;
        if (got !== pack(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,4'h0,4'd0,0)) begin
            failures++;
            $display("[TB] FAIL mid_reset_release got=%h expected=%h", got,
                     pack(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,4'h0,4'd0,0));
        end
    endtask

    task automatic test_illegal();
        logic [21:0] got;
        logic [21:0] halt_v;
        halt_v = pack(0,0,0,0,2'b00,2'b00,2'b00,0,2'b00,4'h0,4'd15,1);
        op = 7'b1111111; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        #1;
        @(negedge clk);
        got = observed();
        checks++;
        if (got !== pack(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,4'h0,4'd1,0)) begin
            failures++;
            $display("[TB] FAIL illegal_decode got=%h expected=%h", got,
                     pack(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,4'h0,4'd1,0));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            got = observed();
            checks++;
            if (got !== halt_v) begin
                failures++;
                $display("[TB] FAIL halt cycle=%0d got=%h expected=%h", i, got, halt_v);
            end
        end
        reset_n = 1'b0;
        #1;
        got = observed();
        checks++;
        if (got !== 22'h0) begin
            failures++;
            $display("[TB] FAIL halt_reset got=%h expected=%h", got, 22'h0);
        end
        @(negedge clk);
        op = 7'b0;
        reset_n = 1'b1;
        #1;
        got = observed();
        checks++;
        if (got !== pack(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,4'h0,4'd0,0)) begin
            failures++;
            $display("[TB] FAIL halt_release got=%h expected=%h", got,
                     pack(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,4'h0,4'd0,0));
        end
    endtask

    // lw, sw, add straight after reset: 3 retired, 5+4+4 = 13 cycles.
    task automatic test_back_to_back();
        test_lw();
        test_sw();
        test_r_type("add", 3'b000, 1'b0, 4'b0000);
`ifdef MCYC_PERF_EN
        checks++;
        if (instret_cnt !== 32'd3) begin
            failures++;
            $display("[TB] FAIL instret got=%0d expected=3", instret_cnt);
        end
        checks++;
        if (cycle_cnt !== 32'd13) begin
            failures++;
            $display("[TB] FAIL cycle_cnt got=%0d expected=13", cycle_cnt);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_r_type("sra", 3'b101, 1'b1, 4'b1000);
        test_r_type("srl", 3'b101, 1'b0, 4'b0111);
        test_r_type("sub", 3'b000, 1'b1, 4'b0001);
        test_r_type("unsup_f3", 3'b011, 1'b0, 4'b0000);
        test_addi();
        test_branch();
        test_jal();
        test_mid_reset();
        test_illegal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
